// File: rtl/banked_tensor_ram_pkg.sv
// Shared types for the banked tensor store: byte, lane word and tensor coordinate.
package banked_tensor_ram_pkg;

  localparam int unsigned BANK_WIDTH = 8;
  localparam int unsigned LANE_WIDTH = 32;
  localparam int unsigned COORD_W    = 8;

  typedef logic signed [BANK_WIDTH-1:0] int8_t;
  typedef logic [LANE_WIDTH-1:0]        lane_t;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] channel;
  } tensor_coord_t;

endpackage

// File: rtl/banked_tensor_ram_if.sv
// Write/read/swap request bus and read-side status of the banked tensor store.
interface banked_tensor_ram_if #(
  parameter int unsigned NUM_BANKS   = 16,
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned MAX_N       = 64,
  parameter int unsigned MAX_NUM_CH  = 64
);
  import banked_tensor_ram_pkg::*;

  localparam int unsigned WORD_BITS = NUM_BANKS * BANK_WIDTH;
  localparam int unsigned NUM_LANES = WORD_BITS / LANE_WIDTH;
  localparam int unsigned ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam int unsigned N_BITS    = $clog2(MAX_N);
  localparam int unsigned CH_BITS   = $clog2(MAX_NUM_CH + 1);

  logic                 write_en;
  logic [N_BITS-1:0]    write_row;
  logic [N_BITS-1:0]    write_col;
  logic [CH_BITS-1:0]   write_channel;
  logic [N_BITS-1:0]    num_cols;
  logic [CH_BITS-1:0]   num_channels;
  int8_t                data_in;
  logic                 read_en;
  logic [ADDR_BITS-1:0] read_addr;
  logic                 swap;
  logic [WORD_BITS-1:0] data_out;
  lane_t                dout_lanes [NUM_LANES];
  logic                 rd_valid;
  logic                 wr_buf_sel;
  logic                 wr_oob_err;
  logic                 rd_oob_err;

  modport master (
    output write_en, write_row, write_col, write_channel, num_cols, num_channels,
           data_in, read_en, read_addr, swap,
    input  data_out, dout_lanes, rd_valid, wr_buf_sel, wr_oob_err, rd_oob_err
  );

  modport slave (
    input  write_en, write_row, write_col, write_channel, num_cols, num_channels,
           data_in, read_en, read_addr, swap,
    output data_out, dout_lanes, rd_valid, wr_buf_sel, wr_oob_err, rd_oob_err
  );

endinterface

// File: rtl/banked_tensor_ram_tensor_addr_gen.sv
// Registered (row*cols+col)*channels+channel linearisation with a bounds flag.
module banked_tensor_ram_tensor_addr_gen
  import banked_tensor_ram_pkg::*;
#(
  parameter int unsigned LIMIT = 2048,
  parameter int unsigned BA_W  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  tensor_coord_t      coord,
  input  logic [COORD_W-1:0] num_cols,
  input  logic [COORD_W-1:0] num_channels,
  output logic               valid_q,
  output logic               oob_q,
  output logic [BA_W-1:0]    addr_q
);

  // Full-precision product so the bound check never sees a wrapped address.
  localparam int unsigned PROD_W = 3 * COORD_W + 1;

  logic [PROD_W-1:0] linear;
  logic              valid_d;
  logic              oob_d;
  logic [BA_W-1:0]   addr_d;

  always_comb begin
    linear  = (PROD_W'(coord.row) * PROD_W'(num_cols) + PROD_W'(coord.col))
              * PROD_W'(num_channels) + PROD_W'(coord.channel);
    valid_d = en;
    oob_d   = linear >= PROD_W'(LIMIT);
    addr_d  = BA_W'(linear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      oob_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      oob_q   <= oob_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: rtl/banked_tensor_ram.sv
// Banked int8 tensor store: byte writes by (row,col,channel), word reads,
// write-first bypass, sticky bounds errors and optional ping-pong buffers.
module banked_tensor_ram
  import banked_tensor_ram_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 16,
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned MAX_N       = 64,
  parameter int unsigned MAX_NUM_CH  = 64,
  parameter int unsigned PING_PONG   = 0
) (
  input  logic                clk,
  input  logic                reset,
  banked_tensor_ram_if.slave  bus
);

  localparam int unsigned WORD_BITS = NUM_BANKS * BANK_WIDTH;
  localparam int unsigned NUM_LANES = WORD_BITS / LANE_WIDTH;
  localparam int unsigned ADDR_BITS = $clog2(DEPTH_WORDS);
  localparam int unsigned N_BITS    = $clog2(MAX_N);
  localparam int unsigned CH_BITS   = $clog2(MAX_NUM_CH + 1);
  localparam int unsigned LOG_NB    = $clog2(NUM_BANKS);
  localparam int unsigned BA_W      = $clog2(DEPTH_WORDS * NUM_BANKS) + 1;
  localparam int unsigned ENTRY_W   = BA_W - LOG_NB;
  localparam int unsigned NUM_BUFS  = (PING_PONG != 0) ? 2 : 1;
  localparam int unsigned MEM_DEPTH = NUM_BUFS * DEPTH_WORDS;
  localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);

  tensor_coord_t           wr_coord;
  logic                    s1_valid, s1_oob;
  logic [BA_W-1:0]         s1_addr;
  int8_t                   s1_data_q, s1_data_d;
  logic                    s1_buf_q, s1_buf_d;
  logic                    s2_valid_q, s2_valid_d, s2_oob_q, s2_oob_d, s2_buf_q, s2_buf_d;
  logic [BA_W-1:0]         s2_addr_q, s2_addr_d;
  int8_t                   s2_data_q, s2_data_d;
  logic                    wr_buf_sel_q, wr_buf_sel_d;
  logic                    wr_oob_err_q, wr_oob_err_d, rd_oob_err_q, rd_oob_err_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [WORD_BITS-1:0]    data_out_q, data_out_d;
  lane_t                   dout_lanes_q [NUM_LANES];
  lane_t                   dout_lanes_d [NUM_LANES];

  logic [LOG_NB-1:0]       s2_bank;
  logic [ENTRY_W-1:0]      s2_entry;
  logic                    mem_we, rd_buf, rd_oob;
  logic [MEM_AW-1:0]       mem_wr_idx, mem_rd_idx;
  logic [NUM_BANKS-1:0][BANK_WIDTH-1:0] rd_word;
  logic [NUM_BANKS-1:0][BANK_WIDTH-1:0] mem [MEM_DEPTH];

  assign wr_coord = '{row:     COORD_W'(N_BITS'(bus.write_row)),
                      col:     COORD_W'(N_BITS'(bus.write_col)),
                      channel: COORD_W'(CH_BITS'(bus.write_channel))};

  banked_tensor_ram_tensor_addr_gen #(
    .LIMIT (DEPTH_WORDS * NUM_BANKS),
    .BA_W  (BA_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .en           (bus.write_en),
    .coord        (wr_coord),
    .num_cols     (COORD_W'(bus.num_cols)),
    .num_channels (COORD_W'(bus.num_channels)),
    .valid_q      (s1_valid),
    .oob_q        (s1_oob),
    .addr_q       (s1_addr)
  );

  // Commit-stage decode and the word read, with the committing byte forwarded.
  always_comb begin
    s2_bank    = s2_addr_q[LOG_NB-1:0];
    s2_entry   = s2_addr_q[BA_W-1:LOG_NB];
    mem_we     = s2_valid_q & ~s2_oob_q & ~reset;
    mem_wr_idx = MEM_AW'({31'd0, s2_buf_q} * DEPTH_WORDS + 32'(s2_entry));
    rd_buf     = (PING_PONG != 0) & ~wr_buf_sel_q;
    rd_oob     = {1'b0, bus.read_addr} >= (ADDR_BITS + 1)'(DEPTH_WORDS);
    mem_rd_idx = MEM_AW'({31'd0, rd_buf} * DEPTH_WORDS + 32'(bus.read_addr));
    rd_word    = mem[mem_rd_idx];
    if (s2_valid_q && !s2_oob_q && (s2_buf_q == rd_buf) &&
        (s2_entry == ENTRY_W'({1'b0, bus.read_addr})))
      rd_word[s2_bank] = s2_data_q;
  end

  always_comb begin
    s1_data_d    = bus.data_in;
    s1_buf_d     = wr_buf_sel_q;
    s2_valid_d   = s1_valid;
    s2_oob_d     = s1_oob;
    s2_addr_d    = s1_addr;
    s2_data_d    = s1_data_q;
    s2_buf_d     = s1_buf_q;
    wr_buf_sel_d = wr_buf_sel_q;
    wr_oob_err_d = wr_oob_err_q | (s2_valid_q & s2_oob_q);
    rd_oob_err_d = rd_oob_err_q;
    rd_valid_d   = 1'b0;
    data_out_d   = data_out_q;
    if ((PING_PONG != 0) && bus.swap) wr_buf_sel_d = ~wr_buf_sel_q;
    if (bus.read_en) begin
      rd_valid_d = 1'b1;
      if (rd_oob) begin
        rd_oob_err_d = 1'b1;
        data_out_d   = '0;
      end else begin
        data_out_d   = rd_word;
      end
    end
    // Lane 0 carries the most significant 32 bits of the word.
    for (int i = 0; i < NUM_LANES; i++)
      dout_lanes_d[i] = data_out_d[WORD_BITS - 1 - i * LANE_WIDTH -: LANE_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data_q    <= '0;
      s1_buf_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_oob_q     <= 1'b0;
      s2_addr_q    <= '0;
      s2_data_q    <= '0;
      s2_buf_q     <= 1'b0;
      wr_buf_sel_q <= 1'b0;
      wr_oob_err_q <= 1'b0;
      rd_oob_err_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      data_out_q   <= '0;
      dout_lanes_q <= '{default: '0};
    end else begin
      s1_data_q    <= s1_data_d;
      s1_buf_q     <= s1_buf_d;
      s2_valid_q   <= s2_valid_d;
      s2_oob_q     <= s2_oob_d;
      s2_addr_q    <= s2_addr_d;
      s2_data_q    <= s2_data_d;
      s2_buf_q     <= s2_buf_d;
      wr_buf_sel_q <= wr_buf_sel_d;
      wr_oob_err_q <= wr_oob_err_d;
      rd_oob_err_q <= rd_oob_err_d;
      rd_valid_q   <= rd_valid_d;
      data_out_q   <= data_out_d;
      dout_lanes_q <= dout_lanes_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wr_idx][s2_bank] <= s2_data_q;
  end

  assign bus.data_out   = data_out_q;
  assign bus.dout_lanes = dout_lanes_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.wr_buf_sel = wr_buf_sel_q;
  assign bus.wr_oob_err = wr_oob_err_q;
  assign bus.rd_oob_err = rd_oob_err_q;

endmodule
